scan_sel_ctrl: RTL
==================

// Module: scan_sel_ctrl
// PURPOSE
//  Sequential select generator feeding Decoder_2x4 (drives its A[1:0] and E inputs).
//  Cycles A through 0..3 with a programmable dwell per select value, e.g. for 4-digit display multiplexing.
//  Start/stop control, busy status, one-cycle wrap pulse per full rotation.
// PARAMETERS
//  DIV   4   dwell length in clk cycles per select value; legal range 2..65536
// PORTS
//  clk    in   1  system clock; all logic on rising edge
//  rst    in   1  synchronous reset, active-high
//  start  in   1  begin scanning (sampled in IDLE only)
//  stop   in   1  request stop at end of current dwell
//  A      out  2  select to decoder A[1:0]
//  E      out  1  enable to decoder E
//  busy   out  1  1 whenever state != IDLE
//  wrap   out  1  1-cycle pulse: first cycle of digit 0 after a 3->0 rollover
// BEHAVIOUR
//  - Single clock. Reset is synchronous and active-high: rst=1 at an edge -> state IDLE, cnt=0,
//    stop_pend=0, A=2'b00, E=0, busy=0, wrap=0. rst has priority over all other inputs.
//  - All outputs are registered. No combinational input->output paths.
//  - Dwell counter cnt counts 0..DIV-1. It runs only in SCAN. tick = (cnt==DIV-1).
//  - IDLE: A=0, E=0. start=1 -> next cycle SCAN, A=0, E=1, cnt=0. stop in IDLE is ignored,
//    except start&stop in the same cycle: enter SCAN with stop_pend=1.
//    Result: exactly one dwell of digit 0, then IDLE.
//  - SCAN: E=1. stop=1 sets stop_pend (sticky). start is ignored.
//    On tick with stop_pend=1: -> IDLE, A=0, E=0, stop_pend=0, cnt=0.
//    On tick with stop_pend=0: A<=A+1 (3 wraps to 0), cnt<=0.
//    Without SCAN_BLANK_EN this is the next cycle; with it, after BLANK.
//    A stop arriving on the tick cycle itself is honoured on that same tick.
//  - wrap: asserted exactly for the first SCAN cycle with A=0 following a 3->0 rollover.
//    Never asserted on the initial entry from IDLE.
//  - Latency: start edge -> E=1 one cycle later. One rotation = 4*DIV cycles (no blanking).
//  - Reset mid-scan: next cycle IDLE, all outputs 0; any pending stop is discarded.
// CONFIGURATION
//  SCAN_BLANK_EN defined: anti-ghosting blank between digits.
//    On a non-stopping tick, go to BLANK for exactly 1 clk: E=0, A holds old value, busy=1.
//    Then SCAN with A incremented, cnt=0. stop during BLANK sets stop_pend, honoured at the next tick.
//    Rotation = 4*(DIV+1) cycles.
//  SCAN_BLANK_EN undefined: BLANK state absent; E stays 1 continuously while scanning.
// STRUCTURE
//  - Shared package scan_pkg: state encodings (IDLE=2'd0, SCAN=2'd1, BLANK=2'd2)
//    and the constant SEL_MAX=2'd3.
//  - Sub-module tick_gen #(DIV) (clk, rst, run, tick): dwell counter.
//    Width $clog2(DIV). Clears when run=0 or on tick.
//  - Top level holds the FSM, A register, stop_pend and the wrap/busy registers.
// TESTING (DIV=4, SCAN_BLANK_EN undefined unless noted)
//  1. rst=1 for 2 cycles with start=1 -> A=0, E=0, busy=0, wrap=0 throughout.
//  2. start pulse at cycle 0 -> E=1 from cycle 1. A=0 cycles 1-4, 1 cycles 5-8, 2 cycles 9-12,
//     3 cycles 13-16, 0 at cycle 17 with wrap=1 only at cycle 17.
//  3. Scanning, stop pulse at cycle 6 (A=1) -> A=1 through cycle 8, then IDLE at cycle 9:
//     A=0, E=0, busy=0. A later start restarts at A=0.
//  4. start&stop together in IDLE -> E=1, A=0 for cycles 1-4, IDLE at cycle 5; wrap never set.
//  5. rst=1 at cycle 10 mid-scan (A=2) -> cycle 11 all outputs 0. start held during rst is ignored.
//  6. SCAN_BLANK_EN defined, start at 0 -> A=0/E=1 cycles 1-4, E=0/A=0 cycle 5,
//     A=1/E=1 cycles 6-9, E=0 cycle 10. wrap=1 at cycle 21.

Source files
------------

// File: rtl/scan_sel_ctrl_pkg.sv
// Shared definitions for the scan select controller.
// Contents: FSM state encoding and the highest select value.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [1:0] SEL_MAX = 2'd3;

endpackage

// File: rtl/scan_sel_ctrl_tick_gen.sv
// Dwell counter: counts 0..DIV-1 while run=1 and flags the last cycle.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   run  - count enable; counter clears while low
//   tick - high during the final cycle of a dwell (cnt == DIV-1)
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned    CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CNT_MAX);

    // Restart each dwell from zero, and hold at zero whenever not scanning.
    always_ff @(posedge clk) begin
        if (rst || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Sequential select generator for a 2-to-4 decoder (A[1:0], E).
// Steps A through 0..3, dwelling DIV cycles on each value; start/stop control.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - begin scanning (only looked at while idle)
//   stop         - finish at the end of the current dwell
//   A, E         - decoder select and enable (registered)
//   busy         - high whenever not idle (registered)
//   wrap         - one-cycle pulse on the first digit-0 cycle after a 3->0 rollover
// Build option: define SCAN_BLANK_EN to insert a one-cycle blank (E=0) between digits.
module scan_sel_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] A,
    output logic       E,
    output logic       busy,
    output logic       wrap
);

    state_t     state, state_d;
    logic       stop_pend, stop_pend_d;
    logic [1:0] a_d;
    logic       e_d, busy_d, wrap_d;
    logic       run, tick, stop_eff;

    assign run      = (state == SCAN);
    // A stop landing on the tick cycle itself still ends the scan on that tick.
    assign stop_eff = stop_pend | stop;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            A         <= 2'b00;
            E         <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_d;
            stop_pend <= stop_pend_d;
            A         <= a_d;
            E         <= e_d;
            busy      <= busy_d;
            wrap      <= wrap_d;
        end
    end

    // Next-state and sticky stop request.
    always_comb begin
        state_d     = state;
        stop_pend_d = stop_pend;
        case (state)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d     = SCAN;
                    stop_pend_d = stop;
                end
            end
            SCAN: begin
                stop_pend_d = stop_eff;
                if (tick && stop_eff) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end
`ifdef SCAN_BLANK_EN
                else if (tick) begin
                    state_d = BLANK;
                end
`endif
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                stop_pend_d = stop_eff;
                state_d     = SCAN;
            end
`endif
            default: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        a_d    = A;
        wrap_d = 1'b0;
        case (state)
            IDLE: begin
                a_d = 2'b00;
            end
            SCAN: begin
                if (tick && stop_eff) begin
                    a_d = 2'b00;
                end
`ifndef SCAN_BLANK_EN
                else if (tick) begin
                    a_d    = A + 2'd1;
                    wrap_d = (A == SEL_MAX);
                end
`endif
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                a_d    = A + 2'd1;
                wrap_d = (A == SEL_MAX);
            end
`endif
            default: begin
                a_d = 2'b00;
            end
        endcase
        e_d    = (state_d == SCAN);
        busy_d = (state_d != IDLE);
    end

endmodule
